// File: rtl/pc_sched_if.sv
// pc_sched_if: bundles the pc_sched request and fetch-control signals.
//   master modport: pipeline side. Drives the stall requests, branch, exception and eret
//                   controls, and observes pc/ce/stall/flush/timeout.
//   slave modport : pc_sched side. Sees the requests and drives the fetch outputs.
interface pc_sched_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              exc_valid;
  logic              eret_valid;
  logic [ADDR_W-1:0] eret_target;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic [5:0]        stall;
  logic              flush;
  logic              timeout;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output branch_valid, branch_target,
    output exc_valid, eret_valid, eret_target,
    input  pc, ce, stall, flush, timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  branch_valid, branch_target,
    input  exc_valid, eret_valid, eret_target,
    output pc, ce, stall, flush, timeout
  );
endinterface

// File: rtl/pc_sched.sv
// pc_sched: fetch-address scheduler for the pipeline front end.
// It owns the program counter and the instruction-memory enable, and it chooses the next PC
// from these sources, in priority order: exception vector, eret target, stall hold, branch,
// pending branch, and sequential fetch. It also merges the per-stage stall requests into the
// 6-bit stall vector, holds on to a branch that arrives while fetch is stalled, and raises a
// sticky watchdog flag when a stall runs for too long.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pc_sched_if.slave
//         inputs : stallreq_{id,ex,mem}, branch_valid/target, exc_valid, eret_valid/target
//         outputs: pc, ce (registered); stall (combinational); flush, timeout (registered)
module pc_sched #(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR  = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR    = ADDR_W'(32'h0000_0020),
  parameter int unsigned       STALL_TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  pc_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {StIdle, StRun, StStall, StFlush} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ce;
  logic              r_flush;
  logic              r_timeout;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [5:0]        w_stall_req;
  logic [5:0]        w_stall;
  logic              w_stalled;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_branch_tgt;
  logic [ADDR_W-1:0] w_eret_tgt;
  logic [CNT_W-1:0]  w_cnt_inc;

  // The deepest stalling stage freezes every stage in front of it.
  always_comb begin
    w_stall_req = 6'b000000;
    if (bus.stallreq_mem) begin
      w_stall_req = 6'b011111;
    end else if (bus.stallreq_ex) begin
      w_stall_req = 6'b001111;
    end else if (bus.stallreq_id) begin
      w_stall_req = 6'b000111;
    end
  end

  // No stall is reported before the first fetch, or in the flush cycle. In the flush cycle,
  // fetch therefore advances even when a request is still being held.
  assign w_stall    = (r_state == StIdle || r_state == StFlush) ? 6'b000000 : w_stall_req;
  assign w_stalled  = w_stall[0];
  assign w_redirect = bus.exc_valid | bus.eret_valid;

  assign w_branch_tgt = bus.branch_target & ALIGN_MASK;
  assign w_eret_tgt   = bus.eret_target & ALIGN_MASK;
  assign w_cnt_inc    = (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pc          <= RESET_VECTOR;
      r_ce          <= 1'b0;
      r_flush       <= 1'b0;
      r_timeout     <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_flush <= 1'b0;
      if (r_state == StIdle) begin
        // The first fetch presents RESET_VECTOR; pc advances from the next edge onward.
        r_ce    <= 1'b1;
        r_state <= StRun;
      end else if (w_redirect) begin
        // An exception or eret overrides stalls and discards any buffered branch.
        r_pc         <= bus.exc_valid ? EXC_VECTOR : w_eret_tgt;
        r_flush      <= 1'b1;
        r_state      <= StFlush;
        r_pend_valid <= 1'b0;
        r_stall_cnt  <= '0;
      end else if (w_stalled) begin
        r_state     <= StStall;
        r_stall_cnt <= w_cnt_inc;
        if (w_cnt_inc == CNT_MAX) begin
          r_timeout <= 1'b1;
        end
        // The latest branch seen during the stall is the one that is kept.
        if (bus.branch_valid) begin
          r_pend_valid  <= 1'b1;
          r_pend_target <= w_branch_tgt;
        end
      end else begin
        r_state      <= StRun;
        r_stall_cnt  <= '0;
        r_pend_valid <= 1'b0;
        if (bus.branch_valid) begin
          r_pc <= w_branch_tgt;
        end else if (r_pend_valid) begin
          r_pc <= r_pend_target;
        end else begin
          r_pc <= r_pc + ADDR_W'(4);
        end
      end
    end
  end

  assign bus.pc      = r_pc;
  assign bus.ce      = r_ce;
  assign bus.stall   = w_stall;
  assign bus.flush   = r_flush;
  assign bus.timeout = r_timeout;

endmodule
